// File: rtl/itr_sequencer.sv
// Interrupt entry/exit sequencer: samples pending interrupts at instruction boundaries,
// saves/restores the return PC and owns GIE. Define ITR_NEST_EN for two-level nesting.
module itr_sequencer #(
    parameter int unsigned PC_W = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            instr_done,
    input  logic            i_pending,
    input  logic [PC_W-1:0] vec_in,
    input  logic [PC_W-1:0] pc_in,
    input  logic            rti,
    input  logic            gie_set,
    input  logic            gie_clr,
    output logic            itr_en,
    output logic            itr_clr,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_next,
    output logic            in_isr,
    output logic [PC_W-1:0] epc,
    output logic            rti_err
);

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_SAVE    = 3'd1;
    localparam logic [2:0] S_VECTOR  = 3'd2;
    localparam logic [2:0] S_SERVICE = 3'd3;
    localparam logic [2:0] S_RETURN  = 3'd4;

`ifdef ITR_NEST_EN
    localparam logic [1:0] DEPTH_MAX = 2'd2;
`else
    localparam logic [1:0] DEPTH_MAX = 2'd1;
`endif

    logic [2:0]      state_q, state_d;
    logic            gie_q, gie_d;
    logic [1:0]      depth_q, depth_d;
    logic [PC_W-1:0] vec_q, vec_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic            rti_err_q, rti_err_d;
    logic            entry_ok;
`ifdef ITR_NEST_EN
    logic [PC_W-1:0] epc1_q, epc1_d;
`endif

    assign entry_ok = instr_done && i_pending && gie_q;

    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        vec_d     = vec_q;
        epc_d     = epc_q;
`ifdef ITR_NEST_EN
        epc1_d    = epc1_q;
`endif
        gie_d     = gie_clr ? 1'b0 : (gie_set ? 1'b1 : gie_q);
        rti_err_d = rti && (state_q == S_RUN || state_q == S_SAVE || state_q == S_VECTOR);

        case (state_q)
            S_RUN: begin
                if (entry_ok) begin
                    state_d = S_SAVE;
                    vec_d   = vec_in;
                    epc_d   = pc_in;
`ifdef ITR_NEST_EN
                    epc1_d  = epc_q;
`endif
                end
            end
            S_SAVE:   state_d = S_VECTOR;
            S_VECTOR: begin
                if (depth_q != DEPTH_MAX) depth_d = depth_q + 2'd1;
                state_d = S_SERVICE;
            end
            S_SERVICE: begin
                // rti takes priority over a nested entry in the same cycle
                if (rti) begin
                    state_d = S_RETURN;
`ifdef ITR_NEST_EN
                end else if (entry_ok && depth_q < DEPTH_MAX) begin
                    state_d = S_SAVE;
                    vec_d   = vec_in;
                    epc_d   = pc_in;
                    epc1_d  = epc_q;
`endif
                end
            end
            S_RETURN: begin
                depth_d = (depth_q == 2'd0) ? 2'd0 : depth_q - 2'd1;
`ifdef ITR_NEST_EN
                epc_d   = epc1_q;
                epc1_d  = '0;
                state_d = (depth_d != 2'd0) ? S_SERVICE : S_RUN;
`else
                state_d = S_RUN;
`endif
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_RUN;
            gie_q     <= 1'b0;
            depth_q   <= 2'd0;
            vec_q     <= '0;
            epc_q     <= '0;
            rti_err_q <= 1'b0;
`ifdef ITR_NEST_EN
            epc1_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gie_q     <= gie_d;
            depth_q   <= depth_d;
            vec_q     <= vec_d;
            epc_q     <= epc_d;
            rti_err_q <= rti_err_d;
`ifdef ITR_NEST_EN
            epc1_q    <= epc1_d;
`endif
        end
    end

    always_comb begin
`ifdef ITR_NEST_EN
        itr_en = gie_q && (state_q == S_RUN || state_q == S_SERVICE);
`else
        itr_en = gie_q && (state_q == S_RUN);
`endif
        itr_clr = (state_q == S_SAVE);
        pc_load = (state_q == S_VECTOR) || (state_q == S_RETURN);
        if (state_q == S_VECTOR)      pc_next = vec_q;
        else if (state_q == S_RETURN) pc_next = epc_q;
        else                          pc_next = '0;
        in_isr  = (depth_q != 2'd0);
        epc     = epc_q;
        rti_err = rti_err_q;
    end

endmodule

// File: tb/tb_itr_sequencer.sv
// Self-checking bench for itr_sequencer: directed scenarios plus a randomized run
// against a schedule-based reference model (honours ITR_NEST_EN).
module tb_itr_sequencer;

    localparam int unsigned PC_W = 8;
`ifdef ITR_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            clr, instr_done, i_pending, rti, gie_set, gie_clr;
    logic [PC_W-1:0] vec_in, pc_in;
    logic            itr_en, itr_clr, pc_load, in_isr, rti_err;
    logic [PC_W-1:0] pc_next, epc;

    int n_checks = 0;
    int n_fail   = 0;

    itr_sequencer #(.PC_W(PC_W)) dut (
        .clk(clk), .clr(clr), .instr_done(instr_done), .i_pending(i_pending),
        .vec_in(vec_in), .pc_in(pc_in), .rti(rti), .gie_set(gie_set), .gie_clr(gie_clr),
        .itr_en(itr_en), .itr_clr(itr_clr), .pc_load(pc_load), .pc_next(pc_next),
        .in_isr(in_isr), .epc(epc), .rti_err(rti_err)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of scheduled one-cycle actions plus ISR depth and saved PCs.
    // kinds: 1 = clear pulse, 2 = vector load, 3 = return load
    int              sched[$];
    logic [PC_W-1:0] stk[$];
    logic [PC_W-1:0] m_vec, m_epc_single;
    int              m_depth;
    bit              m_gie, m_err;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        instr_done = 0; i_pending = 0; rti = 0; gie_set = 0; gie_clr = 0;
        vec_in = '0; pc_in = '0;
    endtask

    task automatic do_reset();
        zero_inputs();
        clr = 1'b0;
        cyc(); cyc();
        clr = 1'b1;
        sched.delete(); stk.delete();
        m_vec = '0; m_epc_single = '0; m_depth = 0; m_gie = 0; m_err = 0;
    endtask

    function automatic logic [PC_W-1:0] m_top();
        if (NEST) return (stk.size() != 0) ? stk[$] : '0;
        return m_epc_single;
    endfunction

    function automatic logic [20:0] model_out();
        int  head;
        bit  en;
        logic [PC_W-1:0] nxt;
        head = (sched.size() != 0) ? sched[0] : 0;
        en   = (head == 0 && (m_depth == 0 || NEST)) ? m_gie : 1'b0;
        nxt  = (head == 2) ? m_vec : ((head == 3) ? m_top() : '0);
        return {en, head == 1, head == 2 || head == 3, nxt, m_depth > 0, m_top(), m_err};
    endfunction

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic model_step();
        int  head;
        bit  old_gie;
        head    = (sched.size() != 0) ? sched[0] : 0;
        old_gie = m_gie;
        m_err   = rti && !(head == 3) && !(head == 0 && m_depth > 0);
        m_gie   = gie_clr ? 1'b0 : (gie_set ? 1'b1 : m_gie);
        if (head != 0) begin
            void'(sched.pop_front());
            if (head == 2) m_depth++;
            if (head == 3) begin
                m_depth--;
                if (NEST) void'(stk.pop_back());
            end
        end else if (m_depth > 0 && rti) begin
            sched.push_back(3);
        end else if (instr_done && i_pending && old_gie &&
                     (m_depth == 0 || (NEST && m_depth < 2))) begin
            sched.push_back(1);
            sched.push_back(2);
            m_vec = vec_in;
            if (NEST) stk.push_back(pc_in);
            else      m_epc_single = pc_in;
        end
    endtask

    function automatic logic [20:0] dut_out();
        return {itr_en, itr_clr, pc_load, pc_next, in_isr, epc, rti_err};
    endfunction

    task automatic test_reset();
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            instr_done = 1'($urandom); i_pending = 1'($urandom); rti = 1'($urandom);
            gie_set = 1'($urandom); gie_clr = 1'($urandom);
            vec_in = 8'($urandom); pc_in = 8'($urandom);
            cyc();
            n_checks++;
            if (dut_out() !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h, expected 0", dut_out());
            end
        end
        zero_inputs();
        clr = 1'b1;
        cyc();
        n_checks++;
        if (itr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_itr_en: got %b, expected 0", itr_en);
        end
        gie_set = 1; cyc(); gie_set = 0;
        n_checks++;
        if (itr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL gie_set_itr_en: got %b, expected 1", itr_en);
        end
    endtask

    task automatic test_basic();
        do_reset();
        gie_set = 1; cyc(); gie_set = 0;
        pc_in = 8'h23; vec_in = 8'h96; i_pending = 1; instr_done = 1;
        cyc();
        instr_done = 0; i_pending = 0; pc_in = 8'hFF; vec_in = 8'h00;
        n_checks++;
        if ({itr_clr, pc_load, itr_en, epc} !== {3'b100, 8'h23}) begin
            n_fail++;
            $display("FAIL entry_save: got clr/load/en/epc %b%b%b %h, expected 100 23",
                     itr_clr, pc_load, itr_en, epc);
        end
        cyc();
        n_checks++;
        if ({itr_clr, pc_load, pc_next} !== {2'b01, 8'h96}) begin
            n_fail++;
            $display("FAIL entry_vector: got clr/load/next %b%b %h, expected 01 96",
                     itr_clr, pc_load, pc_next);
        end
        cyc();
        n_checks++;
        if ({in_isr, pc_load, itr_clr, itr_en} !== {3'b100, NEST}) begin
            n_fail++;
            $display("FAIL service: got isr/load/clr/en %b%b%b%b, expected 100%b",
                     in_isr, pc_load, itr_clr, itr_en, NEST);
        end
        rti = 1; cyc(); rti = 0;
        n_checks++;
        if ({pc_load, pc_next, rti_err} !== {1'b1, 8'h23, 1'b0}) begin
            n_fail++;
            $display("FAIL return_load: got load/next/err %b %h %b, expected 1 23 0",
                     pc_load, pc_next, rti_err);
        end
        cyc();
        n_checks++;
        if ({in_isr, pc_load, itr_en} !== 3'b001) begin
            n_fail++;
            $display("FAIL back_in_run: got isr/load/en %b%b%b, expected 001",
                     in_isr, pc_load, itr_en);
        end
    endtask

    task automatic test_gie_mask();
        do_reset();
        i_pending = 1;
        for (int i = 0; i < 10; i++) begin
            instr_done = 1; cyc();
            n_checks++;
            if ({itr_clr, pc_load} !== 2'b00) begin
                n_fail++;
                $display("FAIL gie_masked: got clr/load %b%b, expected 00", itr_clr, pc_load);
            end
        end
        instr_done = 0;
        gie_set = 1; gie_clr = 1; cyc(); gie_set = 0; gie_clr = 0;
        n_checks++;
        if (itr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL gie_clr_priority: got itr_en %b, expected 0", itr_en);
        end
        instr_done = 1; cyc(); instr_done = 0; i_pending = 0;
        n_checks++;
        if (itr_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL gie_still_masked: got itr_clr %b, expected 0", itr_clr);
        end
    endtask

    task automatic test_rti_cases();
        do_reset();
        rti = 1; cyc(); rti = 0;
        n_checks++;
        if ({rti_err, pc_load} !== 2'b10) begin
            n_fail++;
            $display("FAIL spurious_rti: got err/load %b%b, expected 10", rti_err, pc_load);
        end
        cyc();
        n_checks++;
        if (rti_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rti_err_width: got %b, expected 0", rti_err);
        end
        gie_set = 1; cyc(); gie_set = 0;
        pc_in = 8'h41; vec_in = 8'h70; i_pending = 1; instr_done = 1;
        cyc(); instr_done = 0; i_pending = 0;
        cyc(); cyc();
        rti = 1; instr_done = 1; i_pending = 1; pc_in = 8'h55; vec_in = 8'h66;
        cyc();
        rti = 0; instr_done = 0; i_pending = 0;
        n_checks++;
        if ({pc_load, pc_next, itr_clr, rti_err} !== {1'b1, 8'h41, 2'b00}) begin
            n_fail++;
            $display("FAIL rti_wins: got load/next/clr/err %b %h %b%b, expected 1 41 00",
                     pc_load, pc_next, itr_clr, rti_err);
        end
        cyc();
        n_checks++;
        if ({in_isr, itr_clr, pc_load} !== 3'b000) begin
            n_fail++;
            $display("FAIL after_rti_wins: got isr/clr/load %b%b%b, expected 000",
                     in_isr, itr_clr, pc_load);
        end
    endtask

    task automatic test_reset_mid_isr();
        do_reset();
        gie_set = 1; cyc(); gie_set = 0;
        pc_in = 8'h23; vec_in = 8'h96; i_pending = 1; instr_done = 1;
        cyc(); instr_done = 0; i_pending = 0;
        cyc();
        n_checks++;
        if (pc_load !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_vector: got pc_load %b, expected 1", pc_load);
        end
        #2 clr = 1'b0;
        #1;
        n_checks++;
        if (dut_out() !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset_mid_isr: got %h, expected 0", dut_out());
        end
        cyc(); cyc();
        clr = 1'b1;
        cyc();
        n_checks++;
        if ({pc_load, in_isr, itr_clr, epc} !== 11'd0) begin
            n_fail++;
            $display("FAIL abandoned_sequence: got load/isr/clr/epc %b%b%b %h, expected 000 00",
                     pc_load, in_isr, itr_clr, epc);
        end
    endtask

`ifdef ITR_NEST_EN
    task automatic test_nesting();
        do_reset();
        gie_set = 1; cyc(); gie_set = 0;
        pc_in = 8'h23; vec_in = 8'h96; i_pending = 1; instr_done = 1;
        cyc(); instr_done = 0; i_pending = 0;
        cyc(); cyc();
        pc_in = 8'h98; vec_in = 8'hD7; i_pending = 1; instr_done = 1;
        cyc(); instr_done = 0; i_pending = 0;
        n_checks++;
        if ({itr_clr, epc, in_isr} !== {1'b1, 8'h98, 1'b1}) begin
            n_fail++;
            $display("FAIL nest_save: got clr/epc/isr %b %h %b, expected 1 98 1", itr_clr, epc, in_isr);
        end
        cyc();
        n_checks++;
        if ({pc_load, pc_next} !== {1'b1, 8'hD7}) begin
            n_fail++;
            $display("FAIL nest_vector: got load/next %b %h, expected 1 d7", pc_load, pc_next);
        end
        cyc();
        pc_in = 8'h11; vec_in = 8'h55; i_pending = 1; instr_done = 1;
        cyc(); instr_done = 0; i_pending = 0;
        n_checks++;
        if ({itr_clr, pc_load, epc} !== {2'b00, 8'h98}) begin
            n_fail++;
            $display("FAIL nest_depth_limit: got clr/load/epc %b%b %h, expected 00 98", itr_clr, pc_load, epc);
        end
        rti = 1; cyc(); rti = 0;
        n_checks++;
        if ({pc_load, pc_next} !== {1'b1, 8'h98}) begin
            n_fail++;
            $display("FAIL nest_rti1: got load/next %b %h, expected 1 98", pc_load, pc_next);
        end
        cyc();
        n_checks++;
        if ({in_isr, pc_load, epc} !== {2'b10, 8'h23}) begin
            n_fail++;
            $display("FAIL nest_still_isr: got isr/load/epc %b%b %h, expected 10 23", in_isr, pc_load, epc);
        end
        rti = 1; cyc(); rti = 0;
        n_checks++;
        if ({pc_load, pc_next} !== {1'b1, 8'h23}) begin
            n_fail++;
            $display("FAIL nest_rti2: got load/next %b %h, expected 1 23", pc_load, pc_next);
        end
        cyc();
        n_checks++;
        if (in_isr !== 1'b0) begin
            n_fail++;
            $display("FAIL nest_exit: got in_isr %b, expected 0", in_isr);
        end
    endtask
`else
    task automatic test_no_nesting();
        do_reset();
        gie_set = 1; cyc(); gie_set = 0;
        pc_in = 8'h23; vec_in = 8'h96; i_pending = 1; instr_done = 1;
        cyc(); instr_done = 0; i_pending = 0;
        cyc(); cyc();
        pc_in = 8'h98; vec_in = 8'hD7; i_pending = 1; instr_done = 1;
        cyc(); cyc();
        instr_done = 0; i_pending = 0;
        n_checks++;
        if ({itr_clr, pc_load, itr_en, epc} !== {3'b000, 8'h23}) begin
            n_fail++;
            $display("FAIL no_nest_ignored: got clr/load/en/epc %b%b%b %h, expected 000 23",
                     itr_clr, pc_load, itr_en, epc);
        end
    endtask
`endif

    task automatic test_random();
        logic [20:0] exp_o;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            instr_done = ($urandom_range(2, 0) == 0);
            i_pending  = 1'($urandom);
            rti        = ($urandom_range(5, 0) == 0);
            gie_set    = ($urandom_range(7, 0) == 0);
            gie_clr    = ($urandom_range(15, 0) == 0);
            vec_in     = 8'($urandom);
            pc_in      = 8'($urandom);
            model_step();
            cyc();
            exp_o = model_out();
            n_checks++;
            if (dut_out() !== exp_o) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %h (en,clr,load,next,isr,epc,err), expected %h",
                         i, dut_out(), exp_o);
            end
        end
        zero_inputs();
    endtask

    initial begin
        zero_inputs();
        clr = 1'b0;
        test_reset();
        test_basic();
        test_gie_mask();
        test_rti_cases();
        test_reset_mid_isr();
`ifdef ITR_NEST_EN
        test_nesting();
`else
        test_no_nesting();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
